// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings, flag bundle, segment sizing.
package addsub_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDW = 2'b10;
  localparam logic [1:0] OP_SUBW = 2'b11;

  localparam int unsigned WORD_W = 32;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } addsub_flags_t;

  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// One carry-chain segment: SEG-bit add with carry in and carry out, purely combinational.
module addsub_segment #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = (SEG+1)'(a) + (SEG+1)'(b) + (SEG+1)'(cin);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined RV64 adder/subtractor: carry chain split into STAGES registered segments,
// with word mode, flags, tag passthrough, valid/ready flow control and flush.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned STAGES   = 4,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned HAS_WORD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned MSB  = WIDTH - 1;

  logic adv;

  // Values presented to stage s (ports for s=0, pipeline registers otherwise)
  logic             x_v  [STAGES];
  logic [WIDTH-1:0] x_a  [STAGES];
  logic [WIDTH-1:0] x_b  [STAGES];
  logic [WIDTH-1:0] x_lo [STAGES];
  logic             x_c  [STAGES];
  logic             x_w  [STAGES];
  logic [TAG_W-1:0] x_t  [STAGES];

  // Results produced by stage s: accumulated low sum bits and segment carry
  logic [WIDTH-1:0] y_lo [STAGES];
  logic             y_c  [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [SEG-1:0] seg_sum;

    if (s == 0) begin : g_head
      assign x_v[0]  = in_valid;
      assign x_a[0]  = in_a;
      assign x_b[0]  = in_op[0] ? ~in_b : in_b;
      assign x_c[0]  = in_op[0] | in_cin;
      assign x_lo[0] = '0;
      assign x_w[0]  = (HAS_WORD != 0) && in_op[1];
      assign x_t[0]  = in_tag;
    end else begin : g_skew
      logic             v_q;
      logic             c_q;
      logic             w_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] lo_q;
      logic [TAG_W-1:0] t_q;

      // Only the valid bit needs reset; payload is qualified by it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (flush) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= x_v[s-1];
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q  <= x_a[s-1];
          b_q  <= x_b[s-1];
          lo_q <= y_lo[s-1];
          c_q  <= y_c[s-1];
          w_q  <= x_w[s-1];
          t_q  <= x_t[s-1];
        end
      end

      assign x_v[s]  = v_q;
      assign x_a[s]  = a_q;
      assign x_b[s]  = b_q;
      assign x_lo[s] = lo_q;
      assign x_c[s]  = c_q;
      assign x_w[s]  = w_q;
      assign x_t[s]  = t_q;
    end

    addsub_segment #(.SEG(SEG)) u_seg (
      .a    (x_a[s][s*SEG +: SEG]),
      .b    (x_b[s][s*SEG +: SEG]),
      .cin  (x_c[s]),
      .sum  (seg_sum),
      .cout (y_c[s])
    );

    // Lower slices of lo are already filled, this segment's slice is still zero
    assign y_lo[s] = x_lo[s] | (WIDTH'(seg_sum) << (s * SEG));
  end

  logic [WIDTH-1:0] f_sum;
  logic [WIDTH-1:0] f_a;
  logic [WIDTH-1:0] f_b;
  logic [WIDTH-1:0] f_res;
  addsub_flags_t    f_flags;

  assign f_sum = y_lo[LAST];
  assign f_a   = x_a[LAST];
  assign f_b   = x_b[LAST];

  if (HAS_WORD != 0) begin : g_word
    // Word carry recovered from bit 32: sum ^ a ^ b gives the carry into that bit
    always_comb begin
      f_res        = f_sum;
      f_flags.cout = y_c[LAST];
      f_flags.ovf  = (f_a[MSB] == f_b[MSB]) && (f_sum[MSB] != f_a[MSB]);
      if (x_w[LAST]) begin
        f_res        = {{(WIDTH-WORD_W){f_sum[WORD_W-1]}}, f_sum[WORD_W-1:0]};
        f_flags.cout = f_sum[WORD_W] ^ f_a[WORD_W] ^ f_b[WORD_W];
        f_flags.ovf  = (f_a[WORD_W-1] == f_b[WORD_W-1]) && (f_sum[WORD_W-1] != f_a[WORD_W-1]);
      end
      f_flags.zero = (f_res == '0);
    end
  end else begin : g_full
    always_comb begin
      f_res        = f_sum;
      f_flags.cout = y_c[LAST];
      f_flags.ovf  = (f_a[MSB] == f_b[MSB]) && (f_sum[MSB] != f_a[MSB]);
      f_flags.zero = (f_res == '0);
    end
  end

  // Output stage: flush beats transfer, data only loads with a live result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        out_valid <= x_v[LAST];
      end
      if (!flush && adv && x_v[LAST]) begin
        out_sum  <= f_res;
        out_cout <= f_flags.cout;
        out_ovf  <= f_flags.ovf;
        out_zero <= f_flags.zero;
        out_tag  <= x_t[LAST];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench: three instances (STAGES=1,4,8) share stimulus; checks values, latency, flow control, flush, reset.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        ir [3];
  logic        ov [3];
  logic [63:0] os [3];
  logic        oc [3];
  logic        oo [3];
  logic        oz [3];
  logic [4:0]  ot [3];

  int tests = 0;
  int fails = 0;

  pipelined_addsub #(.WIDTH(64), .STAGES(1), .TAG_W(5), .HAS_WORD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(ov[0]), .out_ready(out_ready), .out_sum(os[0]), .out_cout(oc[0]),
    .out_ovf(oo[0]), .out_zero(oz[0]), .out_tag(ot[0])
  );

  pipelined_addsub #(.WIDTH(64), .STAGES(4), .TAG_W(5), .HAS_WORD(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(ov[1]), .out_ready(out_ready), .out_sum(os[1]), .out_cout(oc[1]),
    .out_ovf(oo[1]), .out_zero(oz[1]), .out_tag(ot[1])
  );

  pipelined_addsub #(.WIDTH(64), .STAGES(8), .TAG_W(5), .HAS_WORD(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(ov[2]), .out_ready(out_ready), .out_sum(os[2]), .out_cout(oc[2]),
    .out_ovf(oo[2]), .out_zero(oz[2]), .out_tag(ot[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  function automatic logic [63:0] stream_a(input int i);
    return 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic logic [63:0] stream_b(input int i);
    return 64'hFFFF_0000_0000_0000 + 64'(i);
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0;
    in_op    = OP_ADD;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_tag   = '0;
  endtask

  // Issue one op into idle pipelines at a negedge, then watch all three for 8 cycles
  task automatic run_single(input string name, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic cin, input logic [4:0] tag,
                            input logic [63:0] es, input logic ec, input logic eo, input logic ez);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_tag    = tag;
    out_ready = 1'b1;
    #1;
    check($sformatf("%s/in_ready", name), 64'(ir[1]), 64'd1);
    @(negedge clk);
    clear_inputs();
    for (int c = 1; c <= 8; c++) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("%s/s%0d/c%0d/valid", name, lat_of(d), c), 64'(ov[d]),
              64'(c == lat_of(d)));
        if (c == lat_of(d)) begin
          check($sformatf("%s/s%0d/sum", name, lat_of(d)), os[d], es);
          check($sformatf("%s/s%0d/cout", name, lat_of(d)), 64'(oc[d]), 64'(ec));
          check($sformatf("%s/s%0d/ovf", name, lat_of(d)), 64'(oo[d]), 64'(eo));
          check($sformatf("%s/s%0d/zero", name, lat_of(d)), 64'(oz[d]), 64'(ez));
          check($sformatf("%s/s%0d/tag", name, lat_of(d)), 64'(ot[d]), 64'(tag));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input int cycles);
    clear_inputs();
    out_ready = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int i_next;
    int rx;
    int extra;
    logic seen;

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    clear_inputs();

    // Reset state
    #2;
    check("reset/out_valid", 64'(ov[1]), 64'd0);
    check("reset/out_sum", os[1], 64'd0);
    check("reset/flags", {61'd0, oc[1], oo[1], oz[1]}, 64'd0);
    check("reset/out_tag", 64'(ot[1]), 64'd0);
    check("reset/in_ready", 64'(ir[1]), 64'd1);
    check("reset/out_valid_s8", 64'(ov[2]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic vectors, each checked at latency 1, 4 and 8
    run_single("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd1,
               64'd0, 1'b1, 1'b0, 1'b1);
    run_single("sub_ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 5'd2,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_single("sub_borrow", OP_SUB, 64'd0, 64'd1, 1'b0, 5'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_single("addw_ovf", OP_ADDW, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 5'd4,
               64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0);
    run_single("subw_zero", OP_SUBW, 64'd5, 64'd5, 1'b0, 5'd5,
               64'd0, 1'b1, 1'b0, 1'b1);
    run_single("add_cin", OP_ADD, 64'd1, 64'd2, 1'b1, 5'd6,
               64'd4, 1'b0, 1'b0, 1'b0);
    run_single("sub_ignores_cin", OP_SUB, 64'd5, 64'd3, 1'b0, 5'd7,
               64'd2, 1'b1, 1'b0, 1'b0);
    run_single("addw_upper_discard", OP_ADDW, 64'h1234_5678_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 5'd8, 64'd0, 1'b1, 1'b0, 1'b1);

    // Stream of 10 ops with a 3-cycle output stall on the STAGES=4 instance
    i_next = 0;
    rx     = 0;
    for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (i_next < 10);
      in_op     = OP_ADD;
      in_a      = stream_a(i_next);
      in_b      = stream_b(i_next);
      in_cin    = 1'b0;
      in_tag    = 5'(i_next);
      #1;
      if (cyc >= 5 && cyc <= 9) begin
        check($sformatf("stream/in_ready/c%0d", cyc), 64'(ir[1]), 64'(cyc < 6 || cyc > 8));
      end
      if (ov[1] && out_ready) begin
        check($sformatf("stream/tag%0d", rx), 64'(ot[1]), 64'(rx));
        check($sformatf("stream/sum%0d", rx), os[1], stream_a(rx) + stream_b(rx));
        rx++;
      end
      if (in_valid && ir[1]) i_next++;
      @(negedge clk);
    end
    check("stream/count", 64'(rx), 64'd10);
    clear_inputs();
    out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (ov[1]) extra++;
      @(negedge clk);
    end
    check("stream/no_duplicates", 64'(extra), 64'd0);

    // Flush with three ops in flight plus a fourth presented in the flush cycle
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_a     = 64'(k + 100);
      in_b     = 64'd1;
      in_tag   = 5'(20 + k);
      @(negedge clk);
    end
    in_tag = 5'd23;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_inputs();
    check("flush/out_valid_s1", 64'(ov[0]), 64'd0);
    check("flush/out_valid_s4", 64'(ov[1]), 64'd0);
    check("flush/out_valid_s8", 64'(ov[2]), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      seen = seen | ov[0] | ov[1] | ov[2];
      @(negedge clk);
    end
    check("flush/never_emitted", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_op    = OP_SUB;
      in_a     = 64'(k + 50);
      in_b     = 64'd3;
      in_tag   = 5'(10 + k);
      if (k == 5) begin
        #1;
        check("areset/pre_valid", 64'(ov[1]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset/out_valid", 64'(ov[1]), 64'd0);
        check("areset/out_sum", os[1], 64'd0);
        check("areset/out_tag", 64'(ot[1]), 64'd0);
        check("areset/in_ready", 64'(ir[1]), 64'd1);
      end
      @(negedge clk);
    end
    clear_inputs();
    check("areset/held_valid_s8", 64'(ov[2]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_single("post_reset_add", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd9,
               64'd0, 1'b1, 1'b0, 1'b1);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
